// File: rtl/aes_pkg.sv
// Shared definitions for the AES decryption controller and its datapath:
// FSM state encoding, state-mux select codes and the round count.
package aes_pkg;

    typedef enum logic [3:0] {
        IDLE,
        KEYEXP,
        LOAD,
        ARK,
        ISR,
        ISB_WAIT,
        ISB,
        IMC,
        DONE
    } aes_state_t;

    localparam logic [1:0] SEL_ARK = 2'd0;
    localparam logic [1:0] SEL_ISB = 2'd1;
    localparam logic [1:0] SEL_IMC = 2'd2;
    localparam logic [1:0] SEL_ISR = 2'd3;

    localparam int NUM_ROUNDS = 10;

endpackage

// File: rtl/aes_control.sv
// Moore controller sequencing the AES-128 inverse cipher on a shared
// datapath: key schedule wait, message load, then ARK / ISR / ISB / IMC
// steps for rounds 0..10, finishing in DONE until AES_START drops.
module aes_control
    import aes_pkg::*;
#(
    parameter int KEYEXP_CYCLES = 12
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       AES_START,
    output logic       AES_DONE,
    output logic       AES_BUSY,
    output logic       ld_msg,
    output logic       ld_state,
    output logic [1:0] state_select,
    output logic [3:0] round,
    output logic [1:0] mix_cols_idx
);

    // The key schedule window covers the entry cycle plus KEYEXP_CYCLES
    // settle cycles, so the wait counter runs from 0 up to KEYEXP_CYCLES.
    localparam logic [7:0] WAIT_LAST  = 8'(KEYEXP_CYCLES);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    aes_state_t state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] wait_q, wait_d;

    // State and counter registers; reset parks in IDLE with all counters cleared
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            round_q <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and counter update; round only advances on leaving ARK 0 or IMC word 3
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (AES_START) begin
                    state_d = KEYEXP;
                    wait_d  = '0;
                    round_d = '0;
                end
            end
            KEYEXP: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = LOAD;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            LOAD: begin
                state_d = ARK;
                round_d = '0;
            end
            ARK: begin
                if (round_q == 4'd0) begin
                    state_d = ISR;
                    round_d = 4'd1;
                end else if (round_q == LAST_ROUND) begin
                    state_d = DONE;
                end else begin
                    state_d = IMC;
                    idx_d   = '0;
                end
            end
            ISR:      state_d = ISB_WAIT;
            ISB_WAIT: state_d = ISB;
            ISB:      state_d = ARK;
            IMC: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = ISR;
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (!AES_START) begin
                    state_d = IDLE;
                    round_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
                idx_d   = '0;
                wait_d  = '0;
            end
        endcase
    end

    // Output decode from the registered state only, so no input reaches an output
    always_comb begin
        AES_DONE     = 1'b0;
        AES_BUSY     = 1'b0;
        ld_msg       = 1'b0;
        ld_state     = 1'b0;
        state_select = SEL_ARK;
        case (state_q)
            KEYEXP: begin
                AES_BUSY = 1'b1;
            end
            LOAD: begin
                AES_BUSY = 1'b1;
                ld_msg   = 1'b1;
            end
            ARK: begin
                AES_BUSY     = 1'b1;
                ld_state     = 1'b1;
                state_select = SEL_ARK;
            end
            ISR: begin
                AES_BUSY     = 1'b1;
                ld_state     = 1'b1;
                state_select = SEL_ISR;
            end
            ISB_WAIT: begin
                AES_BUSY     = 1'b1;
                state_select = SEL_ISB;
            end
            ISB: begin
                AES_BUSY     = 1'b1;
                ld_state     = 1'b1;
                state_select = SEL_ISB;
            end
            IMC: begin
                AES_BUSY     = 1'b1;
                ld_state     = 1'b1;
                state_select = SEL_IMC;
            end
            DONE: begin
                AES_DONE = 1'b1;
            end
            default: begin
                AES_DONE = 1'b0;
            end
        endcase
    end

    assign round        = round_q;
    assign mix_cols_idx = idx_q;

endmodule
